// File: rtl/joystick_debounce.sv
// Synchronizes and debounces the four joystick pins, emits press/release pulses
// and tracks a "last pressed wins" direction for the game logic.
module joystick_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] joystick_raw,
    output logic [3:0] joystick_clean,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [1:0] dir_code,
    output logic       dir_valid
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    p;
    logic [3:0]    s1_q, s2_q;
    logic [3:0]    st_q, st_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    press_q, press_d;
    logic [3:0]    release_q, release_d;
    logic [1:0]    dir_code_q, dir_code_d;
    logic          dir_valid_q, dir_valid_d;
    logic [3:0]    held;

    function automatic logic [1:0] lowestIndex(input logic [3:0] v);
        lowestIndex = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) lowestIndex = 2'(i);
        end
    endfunction

    assign p = ACTIVE_LOW ? ~joystick_raw : joystick_raw;

    // A level is accepted only after it disagrees with the stable level for
    // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
    always_comb begin
        st_d      = st_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == st_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                st_d[i]      = s2_q[i];
                cnt_d[i]     = '0;
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        dir_code_d  = dir_code_q;
        dir_valid_d = dir_valid_q;
        held        = st_q & ~(4'b0001 << dir_code_q);
        if (|press_q) begin
            dir_code_d  = lowestIndex(press_q);
            dir_valid_d = 1'b1;
        end else if (release_q[dir_code_q]) begin
            if (|held) begin
                dir_code_d = lowestIndex(held);
            end else begin
                dir_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            s1_q        <= '0;
            s2_q        <= '0;
            st_q        <= '0;
            press_q     <= '0;
            release_q   <= '0;
            dir_code_q  <= '0;
            dir_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            s1_q        <= p;
            s2_q        <= s1_q;
            st_q        <= st_d;
            press_q     <= press_d;
            release_q   <= release_d;
            dir_code_q  <= dir_code_d;
            dir_valid_q <= dir_valid_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign joystick_clean = st_q;
    assign press_pulse    = press_q;
    assign release_pulse  = release_q;
    assign dir_code       = dir_code_q;
    assign dir_valid      = dir_valid_q;

endmodule

// File: tb/tb_joystick_debounce.sv
// Directed bench for joystick_debounce with DEBOUNCE_CYCLES = 4, active-low pins.
module tb_joystick_debounce;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [3:0] joystick_raw = 4'b1111;
    logic [3:0] joystick_clean, press_pulse, release_pulse;
    logic [1:0] dir_code;
    logic       dir_valid;

    int checkCount = 0;
    int errorCount = 0;

    joystick_debounce #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .joystick_raw  (joystick_raw),
        .joystick_clean(joystick_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .dir_code      (dir_code),
        .dir_valid     (dir_valid)
    );

    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] raw);
        joystick_raw = raw;
    endtask

    // n edges with no pulse expected on any bit.
    task automatic quietEdges(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput({tag, "_nopress"}, {28'd0, press_pulse}, 32'd0);
            checkOutput({tag, "_norel"}, {28'd0, release_pulse}, 32'd0);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] clean, input logic [3:0] prs,
                            input logic [3:0] rel, input logic [1:0] code, input logic valid);
        checkOutput({tag, "_clean"}, {28'd0, joystick_clean}, {28'd0, clean});
        checkOutput({tag, "_press"}, {28'd0, press_pulse}, {28'd0, prs});
        checkOutput({tag, "_release"}, {28'd0, release_pulse}, {28'd0, rel});
        checkOutput({tag, "_code"}, {30'd0, dir_code}, {30'd0, code});
        checkOutput({tag, "_valid"}, {31'd0, dir_valid}, {31'd0, valid});
    endtask

    // Drive a new pin value at edge 0 and verify the pulse at edge 5 and direction at edge 6.
    task automatic transition(input string tag, input logic [3:0] raw, input logic [3:0] clean,
                              input logic [3:0] prs, input logic [3:0] rel,
                              input logic [1:0] oldCode, input logic oldValid,
                              input logic [1:0] newCode, input logic newValid);
        applyStimulus(raw);
        quietEdges(tag, 5);
        tick();
        checkAll({tag, "_e5"}, clean, prs, rel, oldCode, oldValid);
        tick();
        checkAll({tag, "_e6"}, clean, 4'b0000, 4'b0000, newCode, newValid);
    endtask

    initial begin
        // Reset with all pins pressed.
        HRESET = 1'b1;
        applyStimulus(4'b0000);
        repeat (3) tick();
        checkAll("reset", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

        HRESET = 1'b0;
        applyStimulus(4'b1111);
        quietEdges("idle", 6);
        checkAll("idle", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

        transition("clean_up", 4'b1110, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b1);

        // Left bounces: 3 low, 1 high, then steady low.
        applyStimulus(4'b1010);
        quietEdges("bounce_low", 3);
        applyStimulus(4'b1110);
        quietEdges("bounce_high", 1);
        transition("bounce_left", 4'b1010, 4'b0101, 4'b0100, 4'b0000, 2'd0, 1'b1, 2'd2, 1'b1);

        transition("rel_left", 4'b1110, 4'b0001, 4'b0000, 4'b0100, 2'd2, 1'b1, 2'd0, 1'b1);
        transition("press_right", 4'b0110, 4'b1001, 4'b1000, 4'b0000, 2'd0, 1'b1, 2'd3, 1'b1);
        transition("rel_right", 4'b1110, 4'b0001, 4'b0000, 4'b1000, 2'd3, 1'b1, 2'd0, 1'b1);
        transition("rel_up", 4'b1111, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 2'd0, 1'b0);

        transition("simul_press", 4'b1001, 4'b0110, 4'b0110, 4'b0000, 2'd0, 1'b0, 2'd1, 1'b1);
        transition("simul_rel", 4'b1111, 4'b0000, 4'b0000, 4'b0110, 2'd1, 1'b1, 2'd1, 1'b0);

        // Reset while right is mid-count and up is held.
        transition("pre_up", 4'b1110, 4'b0001, 4'b0001, 4'b0000, 2'd1, 1'b0, 2'd0, 1'b1);
        applyStimulus(4'b0110);
        quietEdges("midcount", 4);
        HRESET = 1'b1;
        tick();
        checkAll("mid_reset", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        HRESET = 1'b0;
        quietEdges("after_reset", 5);
        tick();
        checkAll("after_reset_e5", 4'b1001, 4'b1001, 4'b0000, 2'd0, 1'b0);
        tick();
        checkAll("after_reset_e6", 4'b1001, 4'b0000, 4'b0000, 2'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
